// File: rtl/uart_pkg.sv
// Shared serial-line definitions: frame FSM encoding and default widths/rates.
// Used by both the transmit drain stage and the future receive stage.
package uart_pkg;

  localparam int unsigned DefDataWidth  = 8;
  localparam int unsigned DefClksPerBit = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StStart = 3'd3,
    StData  = 3'd4,
    StStop  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO-side pop handshake plus serial line and status of the UART drain stage.
// The slave modport is the drain stage; the master modport is its environment.
interface fifo_uart_tx_if
  import uart_pkg::*;
#(
  parameter int unsigned d_w = DefDataWidth
);

  logic           en;
  logic           empty;
  logic [d_w-1:0] data_in;
  logic           read;
  logic           tx;
  logic           busy;

  modport master (
    output en,
    output empty,
    output data_in,
    input  read,
    input  tx,
    input  busy
  );

  modport slave (
    input  en,
    input  empty,
    input  data_in,
    output read,
    output tx,
    output busy
  );

endinterface

// File: rtl/baud_tick.sv
// Bit-period timer: one-cycle tick on the last cycle of every clks_per_bit period.
// Held at zero while clr is high so the first period after clr is full length.
module baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned clks_per_bit = DefClksPerBit
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    CntW    = $clog2(clks_per_bit);
  localparam logic [CntW-1:0] CntLast = CntW'(clks_per_bit - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = !clr && (cnt_q == CntLast);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word when the FIFO is non-empty and sends it as
// start bit, d_w data bits LSB first, and one stop bit.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned d_w          = DefDataWidth,
  parameter int unsigned clks_per_bit = DefClksPerBit
) (
  input logic           clk,
  input logic           rst,
  fifo_uart_tx_if.slave bus
);

  localparam int unsigned     IdxW    = $clog2(d_w) + 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(d_w - 1);

  uart_state_e     state_q;
  logic [d_w-1:0]  shift_q;
  logic [d_w-1:0]  shift_next;
  logic [IdxW-1:0] idx_q;
  logic            tx_q;
  logic            read_q;
  logic            baud_clr;
  logic            tick;

  // Baud timer only runs while a frame is on the line.
  assign baud_clr   = (state_q == StIdle) || (state_q == StReq) || (state_q == StWait);
  assign shift_next = shift_q >> 1;

  baud_tick #(
    .clks_per_bit(clks_per_bit)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      read_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (bus.en && !bus.empty) begin
            state_q <= StReq;
            read_q  <= 1'b1;
          end
        end
        StReq: begin
          read_q  <= 1'b0;
          state_q <= StWait;
        end
        // FIFO data_out is valid now, one cycle after the pop strobe.
        StWait: begin
          shift_q <= bus.data_in;
          idx_q   <= '0;
          tx_q    <= 1'b0;
          state_q <= StStart;
        end
        StStart: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (tick) begin
            shift_q <= shift_next;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IdxLast) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              tx_q <= shift_next[0];
            end
          end
        end
        StStop: begin
          if (tick) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.read = read_q;
  assign bus.tx   = tx_q;
  assign bus.busy = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small behavioural FIFO (16 deep) upstream.
module tb_fifo_uart_tx;
  import uart_pkg::*;

  logic clk;
  logic rst;
  logic frst;
  logic wr;
  logic [7:0] wdata;

  logic [7:0] mem [16];
  logic [3:0] wp;
  logic [3:0] rp;
  logic [4:0] fcnt;
  logic       underflow;

  int err_cnt = 0;
  int chk_cnt = 0;
  int rd_cnt  = 0;
  int cyc     = 0;

  fifo_uart_tx_if #(.d_w(8)) bus ();

  fifo_uart_tx #(
    .d_w         (8),
    .clks_per_bit(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  assign bus.empty = (fcnt == 5'd0);

  always @(posedge clk) begin
    if (!frst) begin
      wp           <= '0;
      rp           <= '0;
      fcnt         <= '0;
      underflow    <= 1'b0;
      bus.data_in  <= '0;
    end else begin
      if (bus.read && fcnt != 5'd0) begin
        bus.data_in <= mem[rp];
        rp          <= rp + 4'd1;
      end
      if (bus.read && fcnt == 5'd0) underflow <= 1'b1;
      if (wr && fcnt != 5'd16) begin
        mem[wp] <= wdata;
        wp      <= wp + 4'd1;
      end
      fcnt <= fcnt + 5'(wr && fcnt != 5'd16) - 5'(bus.read && fcnt != 5'd0);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.read) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr    = 1'b1;
    wdata = d;
    @(negedge clk);
    wr    = 1'b0;
  endtask

  task automatic wait_read(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.read) seen = 1'b1;
    end
    check({tag, " read"}, 32'(seen), 32'd1);
  endtask

  // Called at the negedge where read is seen; ends on the last stop-bit cycle.
  task automatic rx_frame(input logic [7:0] exp, input string tag, input int drop_en_bit,
                          output int start_cyc);
    logic [9:0] lv;
    logic [7:0] got;
    int bad;
    int rds;
    lv  = {1'b1, exp, 1'b0};
    got = '0;
    bad = 0;
    rds = 0;
    start_cyc = 0;
    @(negedge clk);
    wr = 1'b0;
    check({tag, " wait_tx"}, 32'(bus.tx), 32'd1);
    check({tag, " one_read"}, 32'(bus.read), 32'd0);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0) start_cyc = cyc;
        if (b == drop_en_bit && c == 1) bus.en = 1'b0;
        if (bus.tx !== lv[b]) bad++;
        if (bus.read) rds++;
        if (b >= 1 && b <= 8 && c == 2) got[b-1] = bus.tx;
      end
    end
    check({tag, " levels"}, bad, 0);
    check({tag, " data"}, 32'(got), 32'(exp));
    check({tag, " no_extra_read"}, rds, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int s;
    int prev;
    int bad;
    logic [7:0] v;
    rst    = 1'b0;
    frst   = 1'b0;
    wr     = 1'b0;
    wdata  = '0;
    bus.en = 1'b0;
    prev   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset tx", 32'(bus.tx), 32'd1);
    check("reset read", 32'(bus.read), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    rst  = 1'b1;
    frst = 1'b1;

    // Empty FIFO with en high: nothing may happen.
    r0 = rd_cnt;
    bus.en = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.read !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("idle_empty outputs", bad, 0);
    check("idle_empty reads", rd_cnt - r0, 0);

    // Single frame of A5.
    bus.en = 1'b0;
    push(8'hA5);
    bus.en = 1'b1;
    wait_read("a5", 10);
    check("a5 busy_with_read", 32'(bus.busy), 32'd1);
    rx_frame(8'hA5, "a5", -1, s);
    @(negedge clk);
    check("a5 busy_after", 32'(bus.busy), 32'd0);

    // Sixteen back-to-back frames.
    bus.en = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i));
    r0 = rd_cnt;
    bus.en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_read($sformatf("burst%0d", k), 10);
      rx_frame(8'(k + 1), $sformatf("burst%0d", k), -1, s);
      if (k > 0) check($sformatf("burst%0d gap", k), s - prev, 43);
      prev = s;
    end
    repeat (3) @(negedge clk);
    check("burst reads", rd_cnt - r0, 16);
    check("burst empty", 32'(bus.empty), 32'd1);
    check("burst busy", 32'(bus.busy), 32'd0);

    // en low holds off; dropping en mid-frame finishes that frame only.
    bus.en = 1'b0;
    push(8'h21);
    push(8'h22);
    push(8'h23);
    r0 = rd_cnt;
    repeat (200) @(negedge clk);
    check("en0 reads", rd_cnt - r0, 0);
    bus.en = 1'b1;
    wait_read("endrop", 10);
    rx_frame(8'h21, "endrop", 4, s);
    repeat (100) @(negedge clk);
    check("endrop reads", rd_cnt - r0, 1);
    check("endrop busy", 32'(bus.busy), 32'd0);
    bus.en = 1'b1;
    wait_read("drain22", 10);
    rx_frame(8'h22, "drain22", -1, s);
    wait_read("drain23", 10);
    rx_frame(8'h23, "drain23", -1, s);
    bus.en = 1'b0;

    // Reset during data bit 5 of 3C; 3D must follow intact.
    push(8'h3C);
    push(8'h3D);
    bus.en = 1'b1;
    wait_read("rst3c", 10);
    repeat (2) @(negedge clk);
    repeat (25) @(negedge clk);
    v = 8'h3C;
    check("rst3c bit5", 32'(bus.tx), 32'(v[5]));
    rst = 1'b0;
    @(negedge clk);
    check("rst mid tx", 32'(bus.tx), 32'd1);
    check("rst mid busy", 32'(bus.busy), 32'd0);
    check("rst mid read", 32'(bus.read), 32'd0);
    check("rst mid state", 32'(dut.state_q), 32'(StIdle));
    rst = 1'b1;
    wait_read("after_rst", 10);
    rx_frame(8'h3D, "after_rst", -1, s);
    bus.en = 1'b0;

    // FIFO write and pop in the same cycle with one word held.
    push(8'h55);
    check("wr_rd count_before", 32'(fcnt), 32'd1);
    bus.en = 1'b1;
    wait_read("wr_rd", 10);
    wr    = 1'b1;
    wdata = 8'h66;
    rx_frame(8'h55, "wr_rd55", -1, s);
    check("wr_rd count", 32'(fcnt), 32'd1);
    check("wr_rd underflow", 32'(underflow), 32'd0);
    wait_read("wr_rd66", 10);
    rx_frame(8'h66, "wr_rd66", -1, s);
    @(negedge clk);
    check("final count", 32'(fcnt), 32'd0);
    check("final underflow", 32'(underflow), 32'd0);
    check("final busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
